rns_tc7_add_arbiter: RTL and testbench

Round-robin arbiter sharing a single modulo-7 residue adder among N requesters in the RNS datapath. Each requester presents two binary residues (0..6). The block grants one requester per cycle, converts both operands to 6-bit thermometer code (TC), and adds them mod 7 in TC form. It returns the TC result, the requester ID and an error flag through a single-entry output register with a valid/ready handshake.

---
 rtl/rns_tc7_add_arbiter.sv | 104 ++++++++++
 tb/tb_rns_tc7_add_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/rns_tc7_add_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rns_tc7_add_arbiter: round-robin shared mod-7 residue adder, TC out  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rns_tc7_add_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        req,
  input  logic [3*N-1:0]      a_bin,
  input  logic [3*N-1:0]      b_bin,
  output logic [N-1:0]        gnt,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [5:0]          out_tc,
  output logic [ID_W-1:0]     out_id,
  output logic                out_err
);

  logic [ID_W-1:0] r_ptr;
  logic            r_valid;
  logic [5:0]      r_tc;
  logic [ID_W-1:0] r_id;
  logic            r_err;

  logic            w_can_accept;
  logic            w_any;
  logic [ID_W-1:0] w_gid;
  logic [2:0]      w_a;
  logic [2:0]      w_b;
  logic            w_illegal;
  logic [3:0]      w_sum;
  logic [3:0]      w_mod;
  logic [5:0]      w_tc;

  function automatic logic [ID_W-1:0] f_wrap(input logic [ID_W-1:0] base, input int step);
    int s;
    s = int'(base) + step;
    if (s >= N) s = s - N;
    return s[ID_W-1:0];
  endfunction

  assign w_can_accept = !r_valid || out_ready;

  // Scan downward so the candidate closest to the pointer overwrites the rest.
  always_comb begin
    w_any = 1'b0;
    w_gid = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_can_accept && !rst && req[f_wrap(r_ptr, k)]) begin
        w_any = 1'b1;
        w_gid = f_wrap(r_ptr, k);
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (w_any) gnt[w_gid] = 1'b1;
  end

  assign w_a       = a_bin[3*w_gid +: 3];
  assign w_b       = b_bin[3*w_gid +: 3];
  assign w_illegal = (w_a == 3'b111) || (w_b == 3'b111);
  assign w_sum     = {1'b0, w_a} + {1'b0, w_b};
  assign w_mod     = (w_sum >= 4'd7) ? (w_sum - 4'd7) : w_sum;

  // Thermometer encode: bit i set when the residue exceeds i.
  always_comb begin
    w_tc = '0;
    for (int i = 0; i < 6; i++) begin
      w_tc[i] = (w_mod > 4'(i));
    end
    if (w_illegal) w_tc = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= '0;
      r_valid <= 1'b0;
      r_tc    <= '0;
      r_id    <= '0;
      r_err   <= 1'b0;
    end else if (w_any) begin
      r_valid <= 1'b1;
      r_tc    <= w_tc;
      r_id    <= w_gid;
      r_err   <= w_illegal;
      r_ptr   <= f_wrap(w_gid, 1);
    end else if (r_valid && out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_tc    = r_tc;
  assign out_id    = r_id;
  assign out_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_rns_tc7_add_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rns_tc7_add_arbiter: directed + reference-model bench             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_rns_tc7_add_arbiter;
  localparam int N    = 4;
  localparam int ID_W = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [3*N-1:0]  a_bin = '0;
  logic [3*N-1:0]  b_bin = '0;
  logic            out_ready = 1'b1;
  logic [N-1:0]    gnt;
  logic            out_valid;
  logic [5:0]      out_tc;
  logic [ID_W-1:0] out_id;
  logic            out_err;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int         m_ptr   = 0;
  logic       m_valid = 1'b0;
  logic [5:0] m_tc    = '0;
  int         m_id    = 0;
  logic       m_err   = 1'b0;
  logic       m_show  = 1'b0;

  rns_tc7_add_arbiter #(.N(N), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .req(req), .a_bin(a_bin), .b_bin(b_bin),
    .gnt(gnt), .out_valid(out_valid), .out_ready(out_ready),
    .out_tc(out_tc), .out_id(out_id), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] tc_of(input int v);
    logic [5:0] r;
    r = '0;
    for (int i = 0; i < v; i++) r[i] = 1'b1;
    return r;
  endfunction

  function automatic int m_pick();
    if (rst) return -1;
    if (m_valid && !out_ready) return -1;
    for (int k = 0; k < N; k++) begin
      if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk) begin : model
    int g;
    int a;
    int b;
    g = m_pick();
    if (rst) begin
      m_valid <= 1'b0; m_tc <= '0; m_id <= 0; m_err <= 1'b0; m_ptr <= 0; m_show <= 1'b1;
    end else if (g >= 0) begin
      a = int'(a_bin[3*g +: 3]);
      b = int'(b_bin[3*g +: 3]);
      m_valid <= 1'b1;
      m_id    <= g;
      m_show  <= 1'b0;
      m_ptr   <= (g + 1) % N;
      if (a == 7 || b == 7) begin
        m_tc <= '0; m_err <= 1'b1;
      end else begin
        m_tc <= tc_of((a + b) % 7); m_err <= 1'b0;
      end
    end else if (m_valid && out_ready) begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin : cmp
    int g;
    logic [N-1:0] eg;
    g  = m_pick();
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    chk("model_gnt", 32'(gnt), 32'(eg));
    chk("model_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid || m_show) begin
      chk("model_tc", 32'(out_tc), 32'(m_tc));
      chk("model_id", 32'(out_id), 32'(m_id));
      chk("model_err", 32'(out_err), 32'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    #3;
  endtask

  task automatic set_op(input int i, input logic [2:0] a, input logic [2:0] b);
    a_bin[3*i +: 3] = a;
    b_bin[3*i +: 3] = b;
  endtask

  initial begin
    set_op(0, 3'd5, 3'd4);
    set_op(1, 3'd6, 3'd6);
    set_op(2, 3'd3, 3'd4);
    set_op(3, 3'd1, 3'd2);
    req = 4'b1111;
    rst = 1'b1;
    tick(); tick();
    look();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_tc", 32'(out_tc), 32'h0);
    chk("rst_id", 32'(out_id), 32'h0);
    chk("rst_err", 32'(out_err), 32'h0);
    tick();
    rst = 1'b0;

    // full round-robin over four requesters
    for (int i = 0; i < 8; i++) begin
      look();
      chk("rr_gnt", 32'(gnt), 32'(1 << (i % 4)));
      if (i > 0) begin
        chk("rr_valid", 32'(out_valid), 32'h1);
        chk("rr_id", 32'(out_id), 32'((i - 1) % 4));
      end
      case (i)
        1: chk("op_5p4", 32'(out_tc), 32'b000011);
        2: chk("op_6p6", 32'(out_tc), 32'b011111);
        3: chk("op_3p4", 32'(out_tc), 32'b000000);
        4: chk("op_1p2", 32'(out_tc), 32'b000111);
        default: ;
      endcase
      tick();
    end

    req = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      look();
      chk("mask_gnt", 32'(gnt), (i % 2 == 0) ? 32'b0010 : 32'b1000);
      tick();
    end

    // backpressure with an illegal-operand request waiting
    out_ready = 1'b0;
    req = 4'b0100;
    set_op(2, 3'd7, 3'd1);
    for (int j = 0; j < 5; j++) begin
      look();
      chk("bp_gnt", 32'(gnt), 32'h0);
      chk("bp_valid", 32'(out_valid), 32'h1);
      chk("bp_id", 32'(out_id), 32'd3);
      chk("bp_tc", 32'(out_tc), 32'b000111);
      tick();
    end
    out_ready = 1'b1;
    look();
    chk("bp_release_gnt", 32'(gnt), 32'b0100);
    tick();
    req = 4'b1001;
    look();
    chk("ill_valid", 32'(out_valid), 32'h1);
    chk("ill_tc", 32'(out_tc), 32'h0);
    chk("ill_err", 32'(out_err), 32'h1);
    chk("ill_id", 32'(out_id), 32'd2);
    chk("ill_ptr_gnt", 32'(gnt), 32'b1000);
    tick();
    req = 4'b0000;
    look();
    chk("legal_err", 32'(out_err), 32'h0);
    chk("legal_id", 32'(out_id), 32'd3);
    chk("legal_tc", 32'(out_tc), 32'b000111);
    tick();
    look();
    chk("drain_valid", 32'(out_valid), 32'h0);

    // reset in the middle of a held result
    set_op(2, 3'd3, 3'd4);
    tick();
    req = 4'b1111;
    out_ready = 1'b0;
    look();
    chk("mid_gnt0", 32'(gnt), 32'b0001);
    tick();
    look();
    chk("mid_hold_gnt", 32'(gnt), 32'h0);
    chk("mid_hold_valid", 32'(out_valid), 32'h1);
    tick();
    rst = 1'b1;
    look();
    chk("mid_rst_gnt", 32'(gnt), 32'h0);
    tick();
    rst = 1'b0;
    look();
    chk("mid_after_valid", 32'(out_valid), 32'h0);
    chk("mid_after_gnt", 32'(gnt), 32'b0001);
    tick();

    // randomised soak checked against the model
    for (int c = 0; c < 400; c++) begin
      req       = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 63) == 0);
      for (int r = 0; r < N; r++) set_op(r, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      tick();
    end
    rst = 1'b0;
    tick();
    look();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
